// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decodes aluop + {inst[30], funct3} into an RV32I ALU command and
// executes it on XLEN-bit operands. Single-cycle ops complete one cycle after
// acceptance; shifts iterate SHIFT_STEP bits per cycle in the SHIFT state.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready       operand-side handshake (in_ready is combinational)
//   aluop, instruction        2-bit aluop and {inst[30], inst[14:12]}
//   op_a, op_b                operands; shift amount = op_b[$clog2(XLEN)-1:0]
//   out_valid / out_ready     result-side handshake
//   result, zero, alucmd      registered result, result==0 flag, decoded command
//   busy                      unit is in the SHIFT state
//   illegal                   (ALU_ILLEGAL_TRAP_EN builds only) op was an illegal decode
//
// Build option: define ALU_ILLEGAL_TRAP_EN to add the illegal port; illegal ops then
// complete with result=0 and illegal=1. Otherwise illegal decodes execute as ADD.

module alu_exec_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [3:0]      instruction,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alucmd,
`ifdef ALU_ILLEGAL_TRAP_EN
  output logic            illegal,
`endif
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] CMD_AND  = 4'b0000;
  localparam logic [3:0] CMD_OR   = 4'b0001;
  localparam logic [3:0] CMD_ADD  = 4'b0010;
  localparam logic [3:0] CMD_XOR  = 4'b0011;
  localparam logic [3:0] CMD_SLL  = 4'b0100;
  localparam logic [3:0] CMD_SRL  = 4'b0101;
  localparam logic [3:0] CMD_SUB  = 4'b0110;
  localparam logic [3:0] CMD_SRA  = 4'b0111;
  localparam logic [3:0] CMD_SLT  = 4'b1000;
  localparam logic [3:0] CMD_SLTU = 4'b1001;

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e          state, state_n;
  logic            out_valid_n, zero_n;
  logic [XLEN-1:0] result_n;
  logic [3:0]      alucmd_n;
  logic [XLEN-1:0] sh_val, sh_val_n;
  logic [SHW-1:0]  sh_rem, sh_rem_n;
  logic [3:0]      sh_cmd, sh_cmd_n;
  logic            sh_sign, sh_sign_n;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic            illegal_n;
`endif

  logic [3:0]      base_cmd, dec_cmd;
  logic            dec_ill, is_shift, accept, last_step;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, shifted, sra_fill;
  logic [CW-1:0]   step;

  // Command decode; illegal encodings collapse to ADD
  always_comb begin
    base_cmd = CMD_ADD;
    dec_ill  = 1'b0;
    unique case (aluop)
      2'b00: base_cmd = CMD_ADD;
      2'b01: base_cmd = CMD_SUB;
      default: begin
        unique case (instruction[2:0])
          3'b000:  base_cmd = (aluop == 2'b10 && instruction[3]) ? CMD_SUB : CMD_ADD;
          3'b001:  base_cmd = CMD_SLL;
          3'b010:  base_cmd = CMD_SLT;
          3'b011:  base_cmd = CMD_SLTU;
          3'b100:  base_cmd = CMD_XOR;
          3'b101:  base_cmd = instruction[3] ? CMD_SRA : CMD_SRL;
          3'b110:  base_cmd = CMD_OR;
          default: base_cmd = CMD_AND;
        endcase
        if (aluop == 2'b10 && instruction[3] &&
            instruction[2:0] != 3'b000 && instruction[2:0] != 3'b101)
          dec_ill = 1'b1;
        if (aluop == 2'b11 && instruction[2:0] == 3'b001 && instruction[3])
          dec_ill = 1'b1;
      end
    endcase
  end

  assign dec_cmd  = dec_ill ? CMD_ADD : base_cmd;
  assign shamt    = op_b[SHW-1:0];
  assign is_shift = (dec_cmd == CMD_SLL) || (dec_cmd == CMD_SRL) || (dec_cmd == CMD_SRA);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Single-cycle datapath; a shift reaching here has shamt 0 and passes op_a through
  always_comb begin
    alu_res = '0;
    unique case (dec_cmd)
      CMD_AND:  alu_res = op_a & op_b;
      CMD_OR:   alu_res = op_a | op_b;
      CMD_ADD:  alu_res = op_a + op_b;
      CMD_XOR:  alu_res = op_a ^ op_b;
      CMD_SUB:  alu_res = op_a - op_b;
      CMD_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      CMD_SLTU: alu_res = XLEN'(op_a < op_b);
      CMD_SLL, CMD_SRL, CMD_SRA: alu_res = op_a;
      default:  alu_res = '0;
    endcase
`ifdef ALU_ILLEGAL_TRAP_EN
    if (dec_ill) alu_res = '0;
`endif
  end

  // Iterative shifter: min(SHIFT_STEP, remaining) bits per cycle
  assign step      = ({1'b0, sh_rem} >= CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : {1'b0, sh_rem};
  assign last_step = ({1'b0, sh_rem} <= CW'(SHIFT_STEP));
  assign sra_fill  = {XLEN{sh_sign}} & ~({XLEN{1'b1}} >> step);

  always_comb begin
    shifted = sh_val >> step;
    if (sh_cmd == CMD_SLL)      shifted = sh_val << step;
    else if (sh_cmd == CMD_SRA) shifted = (sh_val >> step) | sra_fill;
  end

  // Next-state and output-register logic
  always_comb begin
    state_n     = state;
    out_valid_n = out_valid;
    result_n    = result;
    zero_n      = zero;
    alucmd_n    = alucmd;
    sh_val_n    = sh_val;
    sh_rem_n    = sh_rem;
    sh_cmd_n    = sh_cmd;
    sh_sign_n   = sh_sign;
`ifdef ALU_ILLEGAL_TRAP_EN
    illegal_n   = illegal;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (is_shift && shamt != '0) begin
            // accept implies any pending result is being consumed this cycle
            out_valid_n = 1'b0;
            sh_val_n    = op_a;
            sh_rem_n    = shamt;
            sh_cmd_n    = dec_cmd;
            sh_sign_n   = (dec_cmd == CMD_SRA) && op_a[XLEN-1];
            state_n     = SHIFT;
          end else begin
            out_valid_n = 1'b1;
            result_n    = alu_res;
            zero_n      = (alu_res == '0);
            alucmd_n    = dec_cmd;
`ifdef ALU_ILLEGAL_TRAP_EN
            illegal_n   = dec_ill;
`endif
          end
        end else if (out_ready) begin
          out_valid_n = 1'b0;
        end
      end
      SHIFT: begin
        sh_val_n = shifted;
        sh_rem_n = sh_rem - SHW'(step);
        if (last_step) begin
          state_n     = IDLE;
          out_valid_n = 1'b1;
          result_n    = shifted;
          zero_n      = (shifted == '0);
          alucmd_n    = sh_cmd;
`ifdef ALU_ILLEGAL_TRAP_EN
          illegal_n   = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      alucmd    <= CMD_AND;
      sh_val    <= '0;
      sh_rem    <= '0;
      sh_cmd    <= CMD_AND;
      sh_sign   <= 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
      illegal   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      out_valid <= out_valid_n;
      result    <= result_n;
      zero      <= zero_n;
      alucmd    <= alucmd_n;
      sh_val    <= sh_val_n;
      sh_rem    <= sh_rem_n;
      sh_cmd    <= sh_cmd_n;
      sh_sign   <= sh_sign_n;
`ifdef ALU_ILLEGAL_TRAP_EN
      illegal   <= illegal_n;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: two instances (SHIFT_STEP 1 and 4) share stimulus, one
// selected at a time; results are compared against a behavioural model.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, sel;
  logic [1:0]  aluop;
  logic [3:0]  instruction;
  logic [31:0] op_a, op_b;

  logic        ir1, ov1, z1, b1, ir4, ov4, z4, b4;
  logic [31:0] r1, r4;
  logic [3:0]  c1, c4;
  logic        in_ready, out_valid, zero, busy;
  logic [31:0] result;
  logic [3:0]  alucmd;
  logic        iv1, iv4;

  assign iv1       = in_valid & ~sel;
  assign iv4       = in_valid & sel;
  assign in_ready  = sel ? ir4 : ir1;
  assign out_valid = sel ? ov4 : ov1;
  assign zero      = sel ? z4  : z1;
  assign busy      = sel ? b4  : b1;
  assign result    = sel ? r4  : r1;
  assign alucmd    = sel ? c4  : c1;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic il1, il4, illegal;
  assign illegal = sel ? il4 : il1;
`endif

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .aluop(aluop),
    .instruction(instruction), .op_a(op_a), .op_b(op_b), .out_valid(ov1),
    .out_ready(out_ready), .result(r1), .zero(z1), .alucmd(c1),
`ifdef ALU_ILLEGAL_TRAP_EN
    .illegal(il1),
`endif
    .busy(b1));

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .aluop(aluop),
    .instruction(instruction), .op_a(op_a), .op_b(op_b), .out_valid(ov4),
    .out_ready(out_ready), .result(r4), .zero(z4), .alucmd(c4),
`ifdef ALU_ILLEGAL_TRAP_EN
    .illegal(il4),
`endif
    .busy(b4));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: what the instruction means, independent of how the unit sequences it
  function automatic void model(input logic [1:0] op, input logic [3:0] ins,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [3:0] cmd,
                                output bit ill);
    bit b30 = ins[3];
    int f3  = int'(ins[2:0]);
    int sh  = int'(b[4:0]);
    ill = 0;
    if (op == 2'b00) cmd = 4'b0010;
    else if (op == 2'b01) cmd = 4'b0110;
    else begin
      case (f3)
        0: cmd = (op == 2'b10 && b30) ? 4'b0110 : 4'b0010;
        1: cmd = 4'b0100;
        2: cmd = 4'b1000;
        3: cmd = 4'b1001;
        4: cmd = 4'b0011;
        5: cmd = b30 ? 4'b0111 : 4'b0101;
        6: cmd = 4'b0001;
        default: cmd = 4'b0000;
      endcase
      if (op == 2'b10 && b30 && f3 != 0 && f3 != 5) ill = 1;
      if (op == 2'b11 && b30 && f3 == 1) ill = 1;
      if (ill) cmd = 4'b0010;
    end
    case (cmd)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: res = a + b;
      4'b0011: res = a ^ b;
      4'b0100: res = a << sh;
      4'b0101: res = a >> sh;
      4'b0110: res = a - b;
      4'b0111: res = 32'($signed(a) >>> sh);
      4'b1000: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = (a < b) ? 32'd1 : 32'd0;
    endcase
`ifdef ALU_ILLEGAL_TRAP_EN
    if (ill) res = 32'd0;
`endif
  endfunction

  // Issue one op on the selected unit at a negedge and check its completion
  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] ins,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic [3:0]  ec;
    bit          ei;
    int          stp, eb, nb, g;
    model(op, ins, a, b, er, ec, ei);
    stp = sel ? 4 : 1;
    eb  = ((ec == 4'b0100 || ec == 4'b0101 || ec == 4'b0111) && b[4:0] != 0)
          ? (int'(b[4:0]) + stp - 1) / stp : 0;
    aluop = op; instruction = ins; op_a = a; op_b = b;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    chk({tag, "/accept_timeout"}, 32'(g >= 100), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    nb = 0; g = 0;
    while (!out_valid && g < 100) begin
      if (busy && nb == 0) chk({tag, "/in_ready_in_shift"}, 32'(in_ready), 32'd0);
      if (busy) nb++;
      @(negedge clk); g++;
    end
    chk({tag, "/done_timeout"}, 32'(g >= 100), 32'd0);
    chk({tag, "/result"}, result, er);
    chk({tag, "/zero"}, 32'(zero), 32'(er == 32'd0));
    chk({tag, "/alucmd"}, 32'(alucmd), 32'(ec));
    chk({tag, "/busy_cycles"}, 32'(nb), 32'(eb));
`ifdef ALU_ILLEGAL_TRAP_EN
    chk({tag, "/illegal"}, 32'(illegal), 32'(ei));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  rop;
    logic [3:0]  rins;
    logic [31:0] ra, rb;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    aluop = '0; instruction = '0; op_a = '0; op_b = '0;
    #12;
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/result", result, 32'd0);
    chk("rst/zero", 32'(zero), 32'd0);
    chk("rst/alucmd", 32'(alucmd), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("rst/in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    run_op("add", 2'b00, 4'b0000, 32'd5, 32'd7);
    chk("add/const", result, 32'd12);
    run_op("sub", 2'b10, 4'b1000, 32'd3, 32'd3);
    chk("sub/zero_const", 32'(zero), 32'd1);
    run_op("slt", 2'b10, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    chk("slt/const", result, 32'd1);
    run_op("sltu", 2'b10, 4'b0011, 32'hFFFF_FFFF, 32'd1);
    chk("sltu/const", result, 32'd0);
    run_op("beq_sub", 2'b01, 4'b1111, 32'd10, 32'd3);
    run_op("srai_s1", 2'b11, 4'b1101, 32'h8000_0000, 32'd4);
    chk("srai_s1/const", result, 32'hF800_0000);
    run_op("slli0", 2'b11, 4'b0001, 32'h1234_5678, 32'd0);
    run_op("srl31", 2'b10, 4'b0101, 32'h8000_0001, 32'd31);
    run_op("illegal_r", 2'b10, 4'b1110, 32'd5, 32'd6);
    run_op("illegal_i", 2'b11, 4'b1001, 32'd9, 32'd1);
    run_op("addi_b30", 2'b11, 4'b1000, 32'd9, 32'd1);

    // Back-pressure: result held, no accept, then back-to-back hand-over
    @(negedge clk);
    aluop = 2'b00; instruction = 4'b0000; op_a = 32'd10; op_b = 32'd20;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    aluop = 2'b10; instruction = 4'b0100; op_a = 32'h0000_00F0; op_b = 32'h0000_00FF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp/out_valid", 32'(out_valid), 32'd1);
      chk("bp/result", result, 32'd30);
      chk("bp/in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; #1;
    chk("bp/in_ready_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b/out_valid", 32'(out_valid), 32'd1);
    chk("b2b/result", result, 32'h0000_000F);
    chk("b2b/alucmd", 32'(alucmd), 32'b0011);
    @(negedge clk);
    chk("drain/out_valid", 32'(out_valid), 32'd0);

    // Reset mid-shift discards the op
    aluop = 2'b11; instruction = 4'b0001; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("midrst/busy_before", 32'(busy), 32'd1);
    rst = 1'b0; #1;
    chk("midrst/out_valid", 32'(out_valid), 32'd0);
    chk("midrst/busy", 32'(busy), 32'd0);
    chk("midrst/result", result, 32'd0);
    chk("midrst/alucmd", 32'(alucmd), 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("midrst/in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 120; i++) begin
      rop = 2'($urandom); rins = 4'($urandom); ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 4) == 0) rb[4:0] = 5'd0;
      run_op("rand_s1", rop, rins, ra, rb);
    end

    // SHIFT_STEP = 4 instance
    @(negedge clk);
    sel = 1'b1;
    run_op("srai_s4", 2'b11, 4'b1101, 32'h8000_0000, 32'd4);
    chk("srai_s4/const", result, 32'hF800_0000);
    run_op("sll_s4_odd", 2'b10, 4'b0001, 32'h0000_00A5, 32'd7);
    run_op("sra_s4_31", 2'b10, 4'b1101, 32'h8000_0000, 32'd31);
    for (int i = 0; i < 40; i++) begin
      rop = 2'b1 + 2'($urandom_range(0, 2)); rins = 4'($urandom); ra = $urandom; rb = $urandom;
      run_op("rand_s4", rop, rins, ra, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
